score_bcd_counter: RTL and testbench
====================================

# score_bcd_counter

Game-score accumulator that feeds the on-screen number objects. It takes point-award requests from game logic, adds them into a multi-digit BCD score one digit per clock, and publishes a frame-stable copy of the score. A per-object digit-select port returns the 4-bit digit that a number-square object renders.

## Interface
Parameters:
- NUM_DIGITS, 4, number of BCD digits in the score (2..8).
- MAX_ADD, 9, largest accepted award per request; larger `add_value` is clamped to MAX_ADD.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous score clear (new game).
- add_req  in  1  award request; accepted only when `add_ready`=1.
- add_value  in  4  points to add, 0..9.
- add_ready  out  1  high in IDLE only.
- startOfFrame  in  1  one-cycle pulse at VGA frame start.
- digit_sel  in  3  digit position queried; 0 = least significant.
- digit  out  4  displayed digit at `digit_sel`, combinational from the display register.
- score_bcd  out  4*NUM_DIGITS  full displayed score, digit 0 in bits [3:0].
- overflow  out  1  sticky; set when an add carries out of the top digit.

## Operation
- Two score copies: `work` (updated by adder) and `disp` (drives outputs). A `pending` flag marks work≠disp.
- FSM states: IDLE, ADD, DONE.
  - IDLE: `add_ready`=1. On `add_req`, latch carry = min(`add_value`, MAX_ADD), set pos=0, go to ADD.
  - ADD: one digit per cycle. sum = work[pos]+carry (5-bit). If sum≥10, work[pos]=sum−10 and carry=1. Otherwise work[pos]=sum and carry=0. Then pos++.
    - Go to DONE when carry becomes 0, or after processing pos=NUM_DIGITS−1.
  - DONE: set `pending`, handle top-digit carry per Configuration, return to IDLE.
- Display update: on `startOfFrame` with `pending`=1 (evaluated every cycle, any state), copy work→disp and clear `pending`.
  - If DONE and `startOfFrame` coincide, the copy includes DONE's result and `pending` ends at 0.
- `clear`: zeros work, disp, overflow, pending, and the carry register; FSM→IDLE. Any add in progress is aborted. `clear` wins over a simultaneous `add_req`, which is dropped.
- `digit_sel` ≥ NUM_DIGITS returns 4'hF, the blank code for the number bitmap.
- Award of 0 is accepted and passes through ADD for one cycle.

## Timing
- Reset values: add_ready=1 (IDLE), digit=disp[digit_sel]=0 (or 4'hF if out of range), score_bcd=0, overflow=0. work, pending, pos, and carry are all 0.
- Accept at cycle 0. ADD occupies cycles 1..k, where k = number of digits touched (1..NUM_DIGITS). DONE is at cycle k+1, and `add_ready` is high again at cycle k+2.
  - Worst case for NUM_DIGITS=4: ready again 6 cycles after accept.
- Score visible on `digit`/`score_bcd` the cycle after the first `startOfFrame` at or after DONE. The value is stable for the whole frame and never changes mid-frame.
- `add_req` while `add_ready`=0 is ignored. There is no queue; the requester holds `add_req` until it sees ready.
- Reset asserted mid-ADD immediately forces all registers to their reset values.

## Configuration
- SCORE_SATURATE_EN defined: a carry out of the top digit sets every work digit to 9 (999…9) and sets `overflow`. Further adds keep the score at all 9s.
- Not defined: the score wraps modulo 10^NUM_DIGITS, keeping the digits already computed in ADD. `overflow` is still set, and is cleared only by `clear`/reset.

## Structure
- Shared package `score_pkg`:
  - `bcd_digit_t` (logic [3:0]).
  - State enum `score_state_t` {IDLE, ADD, DONE}.
  - Constants BCD_MAX=9 and BLANK_DIGIT=4'hF.
- One sub-module, `bcd_digit_adder`: combinational; inputs digit+carry_in, outputs digit_out and carry_out. Instantiated once and indexed by pos.

## Test plan
- Reset, then add 7 and pulse `startOfFrame` → ready returns 3 cycles after accept; score_bcd=0x0007 after the frame pulse; digit_sel=0 gives 7.
- Score 0x0999, add 1 → 4 ADD cycles, work=0x1000, ready 6 cycles after accept, disp still 0x0999 until `startOfFrame`.
- Score 0x9998, add 5 → with SCORE_SATURATE_EN: 0x9999, overflow=1. Without it: 0x0003, overflow=1.
- `clear` asserted on the same cycle as `add_req`(4) → score 0, FSM stays IDLE, no add occurs.
- `add_value`=15 → clamped to 9. `add_req` held during busy is accepted exactly once, on the first cycle ready is high. `digit_sel`=5 returns 4'hF.
- `startOfFrame` on the DONE cycle → disp updates the next cycle and pending=0. Reset pulsed mid-ADD → all outputs return to 0 and add_ready=1.

Source files
------------

// File: rtl/score_bcd_counter_pkg.sv
// Shared types and constants for the BCD score counter.
// Optional build macro used by the counter: SCORE_SATURATE_EN.
package score_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } score_state_t;

   localparam int         BCD_MAX     = 9;
   localparam bcd_digit_t BLANK_DIGIT = 4'hF;

endpackage

// File: rtl/score_bcd_counter_if.sv
// Award-request handshake: add_value is taken on a cycle where add_req and
// add_ready are both high; the requester holds add_req/add_value until then.
interface score_bcd_counter_if;
   logic       add_req;
   logic [3:0] add_value;
   logic       add_ready;

   modport master (output add_req, output add_value, input add_ready);
   modport slave  (input add_req, input add_value, output add_ready);
endinterface

// File: rtl/score_bcd_counter_adder.sv
// Single BCD digit adder: digit plus a carry of up to 9, with decimal carry out.
module bcd_digit_adder
   import score_pkg::*;
(
   input  bcd_digit_t digit,
   input  logic [3:0] carry_in,
   output bcd_digit_t digit_out,
   output logic       carry_out
);

   logic [4:0] sum;

   assign sum = {1'b0, digit} + {1'b0, carry_in};

   always_comb begin
      digit_out = sum[3:0];
      carry_out = 1'b0;
      if (sum > 5'(BCD_MAX)) begin
         digit_out = 4'(sum - 5'd10);
         carry_out = 1'b1;
      end
   end

endmodule

// File: rtl/score_bcd_counter.sv
// Digit-serial BCD score accumulator with a frame-stable display copy.
// Build macro SCORE_SATURATE_EN: top-digit carry pins the score at all 9s.
module score_bcd_counter
   import score_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int MAX_ADD    = 9
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   score_bcd_counter_if.slave      add_bus,
   input  logic                    startOfFrame,
   input  logic [2:0]              digit_sel,
   output bcd_digit_t              digit,
   output logic [4*NUM_DIGITS-1:0] score_bcd,
   output logic                    overflow,
   output logic                    pending,
   output score_state_t            fsm_state
);

   localparam int         PW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] LAST_POS = PW'(NUM_DIGITS - 1);
   localparam logic [3:0] ADD_CAP  = 4'(MAX_ADD);

   score_state_t  state, state_nxt;
   bcd_digit_t    work     [NUM_DIGITS];
   bcd_digit_t    work_nxt [NUM_DIGITS];
   bcd_digit_t    disp     [NUM_DIGITS];
   logic [3:0]    carry, carry_nxt;
   logic [PW-1:0] pos, pos_nxt;
   logic          overflow_nxt;
   logic          pending_nxt;
   bcd_digit_t    sum_digit;
   logic          sum_carry;

   bcd_digit_adder u_adder (
      .digit     (work[pos]),
      .carry_in  (carry),
      .digit_out (sum_digit),
      .carry_out (sum_carry)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      state <= IDLE;
      else if (clear) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      work_nxt     = work;
      carry_nxt    = carry;
      pos_nxt      = pos;
      overflow_nxt = overflow;
      case (state)
         IDLE: begin
            if (add_bus.add_req) begin
               carry_nxt = (add_bus.add_value > ADD_CAP) ? ADD_CAP : add_bus.add_value;
               pos_nxt   = '0;
               state_nxt = ADD;
            end
         end
         ADD: begin
            work_nxt[pos] = sum_digit;
            carry_nxt     = {3'b000, sum_carry};
            pos_nxt       = pos + PW'(1);
            if (!sum_carry || pos == LAST_POS) state_nxt = DONE;
         end
         DONE: begin
            // A carry still held here came out of the top digit.
            if (carry != 4'd0) begin
               overflow_nxt = 1'b1;
`ifdef SCORE_SATURATE_EN
               for (int i = 0; i < NUM_DIGITS; i++) work_nxt[i] = 4'(BCD_MAX);
`else
               work_nxt = work;
`endif
            end
            carry_nxt = 4'd0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // DONE's result is folded into a coincident frame copy via work_nxt.
   assign pending_nxt = pending | (state == DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset || clear) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            work[i] <= '0;
            disp[i] <= '0;
         end
         carry    <= '0;
         pos      <= '0;
         overflow <= 1'b0;
         pending  <= 1'b0;
      end else begin
         work     <= work_nxt;
         carry    <= carry_nxt;
         pos      <= pos_nxt;
         overflow <= overflow_nxt;
         if (startOfFrame && pending_nxt) begin
            disp    <= work_nxt;
            pending <= 1'b0;
         end else begin
            pending <= pending_nxt;
         end
      end
   end

   assign add_bus.add_ready = (state == IDLE);
   assign fsm_state         = state;

   always_comb begin
      digit = BLANK_DIGIT;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         score_bcd[4*i +: 4] = disp[i];
         if (digit_sel == 3'(i)) digit = disp[i];
      end
   end

endmodule

// File: tb/tb_score_bcd_counter.sv
// Randomized self-checking bench for score_bcd_counter against a decimal
// integer model of the score, display copy, overflow and add latency.
module tb_score_bcd_counter;
  import score_pkg::*;

  localparam int N   = 4;
  localparam int MOD = 10000;

  logic               clk = 1'b0;
  logic               reset;
  logic               clear;
  logic               startOfFrame;
  logic [2:0]         digit_sel;
  logic [3:0]         digit;
  logic [4*N-1:0]     score_bcd;
  logic               overflow;
  logic               pending;
  score_state_t       fsm_state;

  score_bcd_counter_if bus ();

  score_bcd_counter #(.NUM_DIGITS(N), .MAX_ADD(9)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .add_bus      (bus.slave),
    .startOfFrame (startOfFrame),
    .digit_sel    (digit_sel),
    .digit        (digit),
    .score_bcd    (score_bcd),
    .overflow     (overflow),
    .pending      (pending),
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  // reference model state
  int m_work, m_disp;
  bit m_pend, m_ovf;
  logic [4*N-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    int r, x;
    r = 0;
    x = v;
    for (int i = 0; i < N; i++) begin
      r = r | ((x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  // digits touched = 1 + number of positions receiving a carry
  function automatic int digits_touched(input int s, input int a);
    int k, p;
    k = 1;
    for (int i = 1; i < N; i++) begin
      p = 10 ** i;
      if ((s % p) + a >= p) k++;
    end
    return k;
  endfunction

  function automatic int clampv(input int v);
    return (v > 9) ? 9 : v;
  endfunction

  task automatic model_add(input int v);
    int s;
    s = m_work + clampv(v);
    if (s >= MOD) begin
      m_ovf = 1'b1;
`ifdef SCORE_SATURATE_EN
      s = MOD - 1;
`else
      s = s - MOD;
`endif
    end
    m_work = s;
    m_pend = 1'b1;
  endtask

  task automatic model_zero();
    m_work = 0;
    m_disp = 0;
    m_pend = 1'b0;
    m_ovf  = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_add(input int v, input bit sof_on_done);
    int k, n;
    k = digits_touched(m_work, clampv(v));
    @(negedge clk);
    check("ready_before_add", 32'(bus.add_ready), 1);
    bus.add_req   = 1'b1;
    bus.add_value = 4'(v);
    @(posedge clk); #1;
    bus.add_req = 1'b0;
    n = 1;
    model_add(v);
    while (!bus.add_ready && n < 20) begin
      if (sof_on_done && n == k + 1) startOfFrame = 1'b1;
      @(posedge clk); #1;
      startOfFrame = 1'b0;
      n++;
    end
    check("add_latency", n, k + 2);
    if (sof_on_done) begin
      m_disp = m_work;
      m_pend = 1'b0;
      check("pending_after_done_sof", 32'(pending), 0);
      check("score_done_sof", 32'(score_bcd), to_bcd(m_disp));
    end
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic frame_pulse();
    logic [4*N-1:0] e;
    @(negedge clk);
    startOfFrame = 1'b1;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    if (m_pend) begin
      m_disp = m_work;
      m_pend = 1'b0;
    end
    exp_q.push_back((4*N)'(to_bcd(m_disp)));
    e = exp_q.pop_front();
    check("score_after_frame", 32'(score_bcd), 32'(e));
    check("pending_after_frame", 32'(pending), 0);
  endtask

  task automatic check_digit(input int sel);
    int e;
    digit_sel = 3'(sel);
    #1;
    e = (sel < N) ? ((m_disp / (10 ** sel)) % 10) : 15;
    check("digit_sel", 32'(digit), e);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_zero();
    check("score_after_clear", 32'(score_bcd), 0);
  endtask

  task automatic load(input int target);
    do_clear();
    while (m_work < target) do_add((target - m_work > 9) ? 9 : target - m_work, 1'b0);
    frame_pulse();
  endtask

  task automatic wait_ready(output int n);
    n = 1;
    while (!bus.add_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic held_add(input int v);
    int k1, k2, n;
    k1 = digits_touched(m_work, clampv(v));
    @(negedge clk);
    bus.add_req   = 1'b1;
    bus.add_value = 4'(v);
    @(posedge clk); #1;
    model_add(v);
    wait_ready(n);
    check("held_first_latency", n, k1 + 2);
    k2 = digits_touched(m_work, clampv(v));
    @(posedge clk); #1;
    bus.add_req = 1'b0;
    model_add(v);
    check("held_second_accept", 32'(bus.add_ready), 0);
    wait_ready(n);
    check("held_second_latency", n, k2 + 2);
  endtask

  initial begin
    reset         = 1'b1;
    clear         = 1'b0;
    startOfFrame  = 1'b0;
    digit_sel     = 3'd0;
    bus.add_req   = 1'b0;
    bus.add_value = 4'd0;
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(bus.add_ready), 1);
    check("reset_score", 32'(score_bcd), 0);
    check("reset_overflow", 32'(overflow), 0);
    check("reset_pending", 32'(pending), 0);
    check_digit(0);
    check_digit(5);
    @(negedge clk);
    reset = 1'b0;

    // add 7 from zero
    do_add(7, 1'b0);
    check("score_before_frame", 32'(score_bcd), 0);
    frame_pulse();
    check("score_0007", 32'(score_bcd), 32'h0007);
    check_digit(0);

    // ripple through three nines
    load(999);
    do_add(1, 1'b0);
    check("disp_held_0999", 32'(score_bcd), 32'h0999);
    frame_pulse();
    check("score_1000", 32'(score_bcd), 32'h1000);

    // top-digit carry
    load(9998);
    do_add(5, 1'b0);
    frame_pulse();
`ifdef SCORE_SATURATE_EN
    check("score_top_carry", 32'(score_bcd), 32'h9999);
`else
    check("score_top_carry", 32'(score_bcd), 32'h0003);
`endif
    check("overflow_top_carry", 32'(overflow), 1);
    do_add(9, 1'b0);
    frame_pulse();

    // clear beats a simultaneous request
    @(negedge clk);
    clear         = 1'b1;
    bus.add_req   = 1'b1;
    bus.add_value = 4'd4;
    @(posedge clk); #1;
    clear       = 1'b0;
    bus.add_req = 1'b0;
    model_zero();
    check("clear_add_ready", 32'(bus.add_ready), 1);
    check("clear_overflow", 32'(overflow), 0);
    repeat (3) @(posedge clk);
    frame_pulse();
    check("clear_score", 32'(score_bcd), 0);

    // clamp, held request, blank digit, frame on DONE
    do_add(15, 1'b0);
    frame_pulse();
    check("score_clamped", 32'(score_bcd), 32'h0009);
    held_add(6);
    frame_pulse();
    check("score_held", 32'(score_bcd), 32'h0021);
    check_digit(5);
    do_add(3, 1'b1);
    do_add(0, 1'b0);
    frame_pulse();

    // reset in the middle of a ripple
    load(999);
    @(negedge clk);
    bus.add_req   = 1'b1;
    bus.add_value = 4'd1;
    @(posedge clk); #1;
    bus.add_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    model_zero();
    check("midadd_reset_score", 32'(score_bcd), 0);
    check("midadd_reset_ready", 32'(bus.add_ready), 1);
    check("midadd_reset_overflow", 32'(overflow), 0);
    check("midadd_reset_pending", 32'(pending), 0);
    @(negedge clk);
    reset = 1'b0;
    frame_pulse();

    // randomized traffic near the top of the range
    load(9900);
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 15) == 0) do_clear();
      else do_add(int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) frame_pulse();
      else check("disp_stable", 32'(score_bcd), to_bcd(m_disp));
      check_digit(int'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
